// File: rtl/mul_pkg.sv
// Shared types and constants for the multiplier issue controller.
// Stage records carry everything a response needs, so the output side needs no extra decode.
package mul_pkg;

    localparam int MUL_N_DEFAULT   = 32;
    localparam int MUL_LAT_DEFAULT = 2;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
        logic n;
    } mul_flags_t;

    typedef enum logic {
        TAG_REQ0 = 1'b0,
        TAG_REQ1 = 1'b1
    } mul_tag_t;

    // Result field is sized for the default operand width; the top is built with N = MUL_N_DEFAULT.
    typedef struct packed {
        logic                     valid;
        mul_tag_t                 tag;
        logic [MUL_N_DEFAULT-1:0] result;
        mul_flags_t               flags;
    } mul_stage_t;

endpackage

// File: rtl/multiplicator.sv
// Combinational N x N multiplier returning the low N bits and {z,c,v,n} flags.
// c: unsigned product overflows N bits; v: signed product overflows N bits.
module multiplicator #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    logic [2*N-1:0] prod_u;
    logic [N-1:0]   hi_s;
    logic           z, c, v, n;

    assign prod_u = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    assign result = prod_u[N-1:0];

    // Signed high half derived from the unsigned one; the low half is identical for both.
    assign hi_s = prod_u[2*N-1:N] - (a[N-1] ? b : '0) - (b[N-1] ? a : '0);

    assign z = (result == '0);
    assign c = |prod_u[2*N-1:N];
    assign v = (hi_s != {N{result[N-1]}});
    assign n = result[N-1];

    assign flags = {z, c, v, n};

endmodule

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a one-hot grant.
// The pointer moves to the loser after every transfer and holds otherwise.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant,
    output logic       sel
);

    logic       prio_reg;
    logic [1:0] grant_raw;

    always_comb begin
        grant_raw = req;
        if (req == 2'b11) begin
            grant_raw = prio_reg ? 2'b10 : 2'b01;
        end
    end

    // sel ignores en so flush/reset never sit on the operand-mux select path.
    assign sel   = grant_raw[1];
    assign grant = en ? grant_raw : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_reg <= 1'b0;
        end else if (|grant) begin
            prio_reg <= grant[0];
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Shares one multiplicator between two requesters: round-robin issue, LAT result stages,
// tagged responses, and a flush that squashes everything in flight.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int N   = MUL_N_DEFAULT,
    parameter int LAT = MUL_LAT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         resp0_valid,
    output logic         resp1_valid,
    output logic [N-1:0] resp_result,
    output logic [3:0]   resp_flags,
    output logic         busy
);

    logic [1:0]   grant;
    logic         sel;
    logic         accept_en;
    logic         transfer;
    logic [N-1:0] op_a, op_b;
    logic [N-1:0] mul_result;
    logic [3:0]   mul_flags;
    logic [LAT:1] stage_valid;
    mul_stage_t   last_stage;

    assign accept_en = ~flush & rst_n;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({req1_valid, req0_valid}),
        .en    (accept_en),
        .grant (grant),
        .sel   (sel)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign transfer   = |grant;

    assign op_a = sel ? req1_a : req0_a;
    assign op_b = sel ? req1_b : req0_b;

    multiplicator #(N) u_mul (
        .a      (op_a),
        .b      (op_b),
        .result (mul_result),
        .flags  (mul_flags)
    );

    genvar gi;
    generate
        for (gi = 1; gi <= LAT; gi++) begin : g_stage
            mul_stage_t stage_reg;
            mul_stage_t stage_in;
            logic       load;

            if (gi == 1) begin : g_head
                assign load     = transfer;
                assign stage_in = '{valid:  1'b1,
                                    tag:    (sel ? TAG_REQ1 : TAG_REQ0),
                                    result: mul_result,
                                    flags:  mul_flags_t'(mul_flags)};
            end else begin : g_tail
                assign load     = g_stage[gi-1].stage_reg.valid;
                assign stage_in = g_stage[gi-1].stage_reg;
            end

            // Data only moves with a valid op, so the output bus holds its last answer when idle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_reg <= '0;
                end else if (flush) begin
                    stage_reg.valid <= 1'b0;
                end else if (load) begin
                    stage_reg <= stage_in;
                end else begin
                    stage_reg.valid <= 1'b0;
                end
            end

            assign stage_valid[gi] = stage_reg.valid;
        end
    endgenerate

    assign last_stage  = g_stage[LAT].stage_reg;
    assign resp0_valid = last_stage.valid && (last_stage.tag == TAG_REQ0);
    assign resp1_valid = last_stage.valid && (last_stage.tag == TAG_REQ1);
    assign resp_result = last_stage.result;
    assign resp_flags  = last_stage.flags;
    assign busy        = |stage_valid;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl: LAT=2 instance for reset/flags/contention,
// LAT=3 instance for flush, LAT=1 instance for back-to-back streaming.
module tb_mul_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  flush, v0, v1, r0, r1, rv0, rv1, busy;
    logic [31:0] a0 [3];
    logic [31:0] b0 [3];
    logic [31:0] a1 [3];
    logic [31:0] b1 [3];
    logic [31:0] res [3];
    logic [3:0]  flg [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_issue_ctrl #(.N(32), .LAT(2)) dut_l2 (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]),
        .req0_valid(v0[0]), .req0_ready(r0[0]), .req0_a(a0[0]), .req0_b(b0[0]),
        .req1_valid(v1[0]), .req1_ready(r1[0]), .req1_a(a1[0]), .req1_b(b1[0]),
        .resp0_valid(rv0[0]), .resp1_valid(rv1[0]), .resp_result(res[0]),
        .resp_flags(flg[0]), .busy(busy[0])
    );

    mul_issue_ctrl #(.N(32), .LAT(3)) dut_l3 (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]),
        .req0_valid(v0[1]), .req0_ready(r0[1]), .req0_a(a0[1]), .req0_b(b0[1]),
        .req1_valid(v1[1]), .req1_ready(r1[1]), .req1_a(a1[1]), .req1_b(b1[1]),
        .resp0_valid(rv0[1]), .resp1_valid(rv1[1]), .resp_result(res[1]),
        .resp_flags(flg[1]), .busy(busy[1])
    );

    mul_issue_ctrl #(.N(32), .LAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .flush(flush[2]),
        .req0_valid(v0[2]), .req0_ready(r0[2]), .req0_a(a0[2]), .req0_b(b0[2]),
        .req1_valid(v1[2]), .req1_ready(r1[2]), .req1_a(a1[2]), .req1_b(b1[2]),
        .resp0_valid(rv0[2]), .resp1_valid(rv1[2]), .resp_result(res[2]),
        .resp_flags(flg[2]), .busy(busy[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One req0 op on the LAT=2 instance; fmask selects which flag bits are checked.
    task automatic single_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_r, input logic [3:0] exp_f,
                             input logic [3:0] fmask);
        v0[0] = 1'b1; a0[0] = a; b0[0] = b;
        #1;
        chk({tag, " ready"}, {31'd0, r0[0]}, 32'd1);
        tick;
        v0[0] = 1'b0;
        chk({tag, " early"}, {31'd0, rv0[0]}, 32'd0);
        tick;
        chk({tag, " resp0"}, {30'd0, rv1[0], rv0[0]}, 32'd1);
        chk({tag, " result"}, res[0], exp_r);
        chk({tag, " flags"}, {28'd0, flg[0] & fmask}, {28'd0, exp_f & fmask});
        tick;
        chk({tag, " pulse end"}, {31'd0, rv0[0]}, 32'd0);
    endtask

    initial begin
        int d;
        logic [31:0] exp_res;
        rst_n = 1'b0;
        flush = '0; v0 = '0; v1 = '0;
        for (int i = 0; i < 3; i++) begin
            a0[i] = '0; b0[i] = '0; a1[i] = '0; b1[i] = '0;
        end

        // Reset: readies held low even with both requesters valid
        v0[0] = 1'b1; v1[0] = 1'b1;
        #1;
        chk("rst ready0", {31'd0, r0[0]}, 32'd0);
        chk("rst ready1", {31'd0, r1[0]}, 32'd0);
        chk("rst busy", {29'd0, busy}, 32'd0);
        chk("rst resp", {26'd0, rv1, rv0}, 32'd0);
        tick;
        tick;
        v0[0] = 1'b0; v1[0] = 1'b0;
        rst_n = 1'b1;
        tick;

        single_op("3x5",     32'd3,          32'd5, 32'd15,         4'b0000, 4'b1111);
        single_op("0x7",     32'd0,          32'd7, 32'd0,          4'b1000, 4'b1111);
        single_op("16x16",   32'h0001_0000,  32'h0001_0000, 32'd0,  4'b1100, 4'b1100);
        single_op("ovf",     32'h4000_0000,  32'd2, 32'h8000_0000,  4'b0011, 4'b1111);
        single_op("neg1x2",  32'hFFFF_FFFF,  32'd2, 32'hFFFF_FFFE,  4'b0101, 4'b1111);

        // Reset with an op in flight: it must vanish
        v0[0] = 1'b1; a0[0] = 32'd9; b0[0] = 32'd9;
        tick;
        v0[0] = 1'b0;
        chk("inflight busy", {31'd0, busy[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", {31'd0, busy[0]}, 32'd0);
        v0[0] = 1'b1; v1[0] = 1'b1;
        #1;
        chk("midrst readies", {30'd0, r1[0], r0[0]}, 32'd0);
        tick;
        chk("midrst resp", {30'd0, rv1[0], rv0[0]}, 32'd0);
        v0[0] = 1'b0; v1[0] = 1'b0;
        rst_n = 1'b1;
        tick;
        chk("postrst resp a", {30'd0, rv1[0], rv0[0]}, 32'd0);
        tick;
        chk("postrst resp b", {30'd0, rv1[0], rv0[0]}, 32'd0);

        // Contention: both valid for 6 cycles, grants 0,1,0,1,0,1
        for (int c = 0; c < 8; c++) begin
            if (c < 6) begin
                v0[0] = 1'b1; v1[0] = 1'b1;
                a0[0] = 32'((c + 1) / 2); a1[0] = 32'(100 + c / 2);
                b0[0] = 32'd2; b1[0] = 32'd2;
            end else begin
                v0[0] = 1'b0; v1[0] = 1'b0;
            end
            #1;
            if (c < 6) begin
                chk($sformatf("cont grant c%0d", c), {30'd0, r1[0], r0[0]},
                    (c % 2 == 0) ? 32'd1 : 32'd2);
            end
            if (c >= 2) begin
                d = c - 2;
                exp_res = (d % 2 == 0) ? 32'(d) : 32'((100 + d / 2) * 2);
                chk($sformatf("cont owner d%0d", d), {30'd0, rv1[0], rv0[0]},
                    (d % 2 == 0) ? 32'd1 : 32'd2);
                chk($sformatf("cont result d%0d", d), res[0], exp_res);
            end
            tick;
        end
        chk("cont idle busy", {31'd0, busy[0]}, 32'd0);

        // Flush on LAT=3: two accepts, then flush
        v0[1] = 1'b1; a0[1] = 32'd6; b0[1] = 32'd7;
        #1;
        chk("fl acc0", {31'd0, r0[1]}, 32'd1);
        tick;
        v0[1] = 1'b0; v1[1] = 1'b1; a1[1] = 32'd9; b1[1] = 32'd9;
        #1;
        chk("fl acc1", {31'd0, r1[1]}, 32'd1);
        tick;
        flush[1] = 1'b1; v0[1] = 1'b1; v1[1] = 1'b1;
        #1;
        chk("fl readies", {30'd0, r1[1], r0[1]}, 32'd0);
        chk("fl busy", {31'd0, busy[1]}, 32'd1);
        chk("fl resp during", {30'd0, rv1[1], rv0[1]}, 32'd0);
        tick;
        flush[1] = 1'b0; v0[1] = 1'b0; v1[1] = 1'b0;
        chk("fl busy after", {31'd0, busy[1]}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("fl no resp c%0d", c), {30'd0, rv1[1], rv0[1]}, 32'd0);
            tick;
        end
        v1[1] = 1'b1; a1[1] = 32'd4; b1[1] = 32'd5;
        #1;
        chk("fl next ready", {31'd0, r1[1]}, 32'd1);
        tick;
        v1[1] = 1'b0;
        tick;
        chk("fl next early", {31'd0, rv1[1]}, 32'd0);
        tick;
        chk("fl next resp1", {30'd0, rv1[1], rv0[1]}, 32'd2);
        chk("fl next result", res[1], 32'd20);
        tick;
        chk("fl next end", {31'd0, rv1[1]}, 32'd0);

        // LAT=1 stream of 8 ops from req1
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) begin
                v1[2] = 1'b1; a1[2] = 32'(c + 1); b1[2] = 32'd3;
            end else begin
                v1[2] = 1'b0;
            end
            #1;
            if (c < 8) begin
                chk($sformatf("l1 ready c%0d", c), {31'd0, r1[2]}, 32'd1);
            end
            if (c > 0) begin
                chk($sformatf("l1 resp c%0d", c), {30'd0, rv1[2], rv0[2]}, 32'd2);
                chk($sformatf("l1 result c%0d", c), res[2], 32'(c * 3));
            end
            tick;
        end
        chk("l1 stream end", {31'd0, rv1[2]}, 32'd0);
        chk("l1 idle busy", {31'd0, busy[2]}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
